draw_rect: RTL and testbench
============================

DRAW_RECT -- requirements
Module: draw_rect

Interface
REQ-001 Parameter RECT_W, default 48, rectangle width in pixels.
REQ-002 Parameter RECT_H, default 64, rectangle height in lines.
REQ-003 Parameter RECT_COLOR, default 12'hF00, rectangle colour (4-bit R, G, B).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  pixel clock (40 MHz); rst  input  1  asynchronous active-high reset.
REQ-005 vcount_in, hcount_in  input  11 each  line and pixel counters from vga_timing.
REQ-006 vsync_in, hsync_in, vblnk_in, hblnk_in  input  1 each  sync and blanking from vga_timing.
REQ-007 rgb_in  input  12  background colour aligned with the timing inputs.
REQ-008 pos_x, pos_y  input  11 each  requested rectangle top-left corner.
REQ-009 pos_valid  input  1  position request valid.
REQ-010 pos_ready  output  1  position request can be accepted.
REQ-011 vcount_out, hcount_out  output  11 each  delayed counters.
REQ-012 vsync_out, hsync_out, vblnk_out, hblnk_out  output  1 each  delayed sync and blanking.
REQ-013 rgb_out  output  12  composed pixel colour.

Function
REQ-014 All *_out timing signals SHALL equal the matching *_in delayed by exactly 2 clk cycles, through a registered 2-stage pipeline.
REQ-015 rgb_out SHALL be 12'h000 while the stage-2 hblnk or vblnk is 1.
REQ-016 Otherwise, rgb_out SHALL be RECT_COLOR when act_x <= hcount < act_x+RECT_W and act_y <= vcount < act_y+RECT_H, and rgb_in delayed by 2 cycles in all other cases.
REQ-017 The rectangle-bound sums SHALL be computed 12 bits wide with no wrap-around, so a rectangle crossing the right or bottom edge is clipped.
REQ-018 The position handshake SHALL use a 2-state FSM: IDLE (pos_ready=1) and PENDING (pos_ready=0).
REQ-019 In IDLE, when pos_valid=1, the FSM SHALL capture pos_x and pos_y into a pending register and move to PENDING.
REQ-020 In PENDING, pos_valid SHALL be ignored.
REQ-021 Frame start is the cycle where vblnk_in rises from 0 to 1, detected with a 1-cycle delayed copy of vblnk_in.
REQ-022 In PENDING, on frame start, the pending value SHALL be copied into act_x and act_y and the FSM SHALL return to IDLE, so pos_ready is 1 on the next cycle.
REQ-023 If a request is accepted in IDLE in the same cycle as frame start, it SHALL be applied at the next frame start, not the current one.
REQ-024 act_x and act_y SHALL change only on frame start, so no visible line is drawn with mixed positions.

Reset
REQ-025 While rst=1, all pipeline registers, *_out and rgb_out SHALL be 0, act_x=act_y=0, the pending register SHALL be 0, and the FSM SHALL be in IDLE with pos_ready=1.
REQ-026 Assertion of rst in the middle of a frame SHALL abandon any pending request.
REQ-027 After rst is released, valid outputs SHALL appear 2 cycles after the first valid inputs.

Structure
REQ-028 Timing constants SHALL come from the shared vga_pkg: VISIBLE_WIDTH=800, VISIBLE_HEIGHT=600, FULL_WIDTH=1056, FULL_HEIGHT=628.
REQ-029 The FSM state enum and the 12-bit colour typedef SHALL be added to vga_pkg.
REQ-030 The 2-stage timing delay SHALL be one sub-module, delay_pipe, parameterised by width and depth.
REQ-031 Compositing logic and the FSM SHALL stay in draw_rect.

Verification
REQ-032 Bench SHALL drive draw_rect from a vga_timing instance plus rgb_in=12'h0F0 and cover the following scenarios.
REQ-033 No position request: every *_out SHALL match its *_in delayed by 2 cycles; the pixel at (0,0) SHALL be F00; (48,0) SHALL be 0F0; (0,64) SHALL be 0F0.
REQ-034 pos=(100,200) with pos_valid pulsed mid-frame: pos_ready SHALL be 0 until the cycle after vblnk_in rises; the next frame SHALL show (100,200) and (147,263) as F00, and (148,200) and (100,264) as 0F0.
REQ-035 pos=(780,590): pixels (780..799, 590..599) SHALL be F00, with no colour in blanking and no wrap onto column 0 or line 0.
REQ-036 pos_valid asserted in the same cycle as vblnk_in rising: the position SHALL be unchanged in the following frame and applied one frame later.
REQ-037 rst asserted for 3 cycles mid-frame while PENDING: outputs SHALL be 0 immediately, pos_ready SHALL be 1, and act SHALL be (0,0) after release.
REQ-038 Every cycle the bench SHALL assert rgb_out==0 whenever hblnk_out or vblnk_out is 1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: timing constants, colour type, position-FSM states
// and a clipped span test used by the rectangle compositor.
package vga_pkg;

    localparam int VISIBLE_WIDTH  = 800;
    localparam int VISIBLE_HEIGHT = 600;
    localparam int FULL_WIDTH     = 1056;
    localparam int FULL_HEIGHT    = 628;

    typedef logic [11:0] color_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } pos_state_t;

    // The limit is formed one bit wider than the counters, so a span that runs
    // past the screen edge is clipped instead of wrapping back to column/line 0.
    function automatic logic in_span(input logic [10:0] v,
                                     input logic [10:0] start,
                                     input logic [11:0] len);
        logic [11:0] lim;
        lim = {1'b0, start} + len;
        return ({1'b0, v} >= {1'b0, start}) && ({1'b0, v} < lim);
    endfunction

endpackage

// File: rtl/delay_pipe.sv
// Generic register pipeline: dout is din delayed by DEPTH clock cycles.
module delay_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/draw_rect.sv
// Overlays a solid rectangle on the incoming VGA stream; the rectangle's
// position is requested by handshake and only takes effect at frame start.
import vga_pkg::*;

module draw_rect #(
    parameter int     RECT_W     = 48,
    parameter int     RECT_H     = 64,
    parameter color_t RECT_COLOR = 12'hF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] vcount_in,
    input  logic [10:0] hcount_in,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        vblnk_in,
    input  logic        hblnk_in,
    input  color_t      rgb_in,
    input  logic [10:0] pos_x,
    input  logic [10:0] pos_y,
    input  logic        pos_valid,
    output logic        pos_ready,
    output logic [10:0] vcount_out,
    output logic [10:0] hcount_out,
    output logic        vsync_out,
    output logic        hsync_out,
    output logic        vblnk_out,
    output logic        hblnk_out,
    output color_t      rgb_out
);

    logic [25:0] timing_in;
    logic [25:0] timing_out;

    assign timing_in = {vcount_in, hcount_in, vsync_in, hsync_in, vblnk_in, hblnk_in};

    delay_pipe #(
        .WIDTH(26),
        .DEPTH(2)
    ) u_timing (
        .clk (clk),
        .rst (rst),
        .din (timing_in),
        .dout(timing_out)
    );

    assign {vcount_out, hcount_out, vsync_out, hsync_out, vblnk_out, hblnk_out} = timing_out;

    pos_state_t  state;
    logic [10:0] pend_x;
    logic [10:0] pend_y;
    logic [10:0] act_x;
    logic [10:0] act_y;
    logic        vblnk_prev;
    logic        frame_start;

    assign frame_start = vblnk_in & ~vblnk_prev;
    assign pos_ready   = (state == IDLE);

    // A request captured on the frame-start cycle itself waits in PENDING
    // until the following frame start, keeping every visible line consistent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pend_x     <= '0;
            pend_y     <= '0;
            act_x      <= '0;
            act_y      <= '0;
            vblnk_prev <= 1'b0;
        end else begin
            vblnk_prev <= vblnk_in;
            case (state)
                IDLE: begin
                    if (pos_valid) begin
                        pend_x <= pos_x;
                        pend_y <= pos_y;
                        state  <= PENDING;
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        act_x <= pend_x;
                        act_y <= pend_y;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    logic   in_rect;
    logic   in_rect_d;
    logic   blank_d;
    color_t rgb_d;

    assign in_rect = in_span(hcount_in, act_x, 12'(RECT_W)) &&
                     in_span(vcount_in, act_y, 12'(RECT_H));

    // Stage 1 resolves the hit test, stage 2 picks the colour so rgb_out
    // lines up with the two-cycle-delayed timing signals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_rect_d <= 1'b0;
            blank_d   <= 1'b0;
            rgb_d     <= '0;
            rgb_out   <= '0;
        end else begin
            in_rect_d <= in_rect;
            blank_d   <= hblnk_in | vblnk_in;
            rgb_d     <= rgb_in;
            if (blank_d) begin
                rgb_out <= '0;
            end else if (in_rect_d) begin
                rgb_out <= RECT_COLOR;
            end else begin
                rgb_out <= rgb_d;
            end
        end
    end

endmodule

// File: tb/tb_draw_rect.sv
// Self-checking bench for draw_rect: sparse VGA frames with directed and
// randomized position requests, compared every cycle against a pixel model.
`timescale 1ns/1ps

module tb_draw_rect;

    localparam int          RW = 48;
    localparam int          RH = 64;
    localparam logic [11:0] RC = 12'hF00;
    localparam logic [11:0] BG = 12'h0F0;

    logic        clk;
    logic        rst;
    logic [10:0] vcount_in, hcount_in;
    logic        vsync_in, hsync_in, vblnk_in, hblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] pos_x, pos_y;
    logic        pos_valid;
    logic        pos_ready;
    logic [10:0] vcount_out, hcount_out;
    logic        vsync_out, hsync_out, vblnk_out, hblnk_out;
    logic [11:0] rgb_out;

    int checks = 0;
    int failures = 0;
    int frameCycle = 0;
    logic started = 1'b0;
    logic [11:0] seen [int];

    draw_rect dut (
        .clk       (clk),
        .rst       (rst),
        .vcount_in (vcount_in),
        .hcount_in (hcount_in),
        .vsync_in  (vsync_in),
        .hsync_in  (hsync_in),
        .vblnk_in  (vblnk_in),
        .hblnk_in  (hblnk_in),
        .rgb_in    (rgb_in),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .pos_valid (pos_valid),
        .pos_ready (pos_ready),
        .vcount_out(vcount_out),
        .hcount_out(hcount_out),
        .vsync_out (vsync_out),
        .hsync_out (hsync_out),
        .vblnk_out (vblnk_out),
        .hblnk_out (hblnk_out),
        .rgb_out   (rgb_out)
    );

    initial clk = 1'b0;
    always #12.5 clk = ~clk;

    typedef struct packed {
        logic [10:0] vc;
        logic [10:0] hc;
        logic        vs;
        logic        hs;
        logic        vb;
        logic        hb;
        logic [11:0] rgb;
    } exp_t;

    // Reference pixel colour straight from the screen-space rule, in plain integers.
    function automatic exp_t mkEntry(input logic [10:0] vc, input logic [10:0] hc,
                                     input logic vs, input logic hs, input logic vb,
                                     input logic hb, input logic [11:0] rgb,
                                     input logic [10:0] ax, input logic [10:0] ay);
        exp_t e;
        int x, y, x0, y0;
        x = int'(hc); y = int'(vc); x0 = int'(ax); y0 = int'(ay);
        e.vc = vc; e.hc = hc; e.vs = vs; e.hs = hs; e.vb = vb; e.hb = hb;
        if (hb || vb)
            e.rgb = 12'h000;
        else if (x >= x0 && x < x0 + RW && y >= y0 && y < y0 + RH)
            e.rgb = RC;
        else
            e.rgb = rgb;
        return e;
    endfunction

    exp_t        h0, h1;
    logic [10:0] mActX, mActY, mPendX, mPendY;
    logic        mReady, mPrevVb;

    // Behavioural model: two-deep history of expected outputs plus the
    // request/frame-start bookkeeping deciding which position a pixel sees.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h0 <= '0; h1 <= '0;
            mActX <= '0; mActY <= '0; mPendX <= '0; mPendY <= '0;
            mReady <= 1'b1; mPrevVb <= 1'b0;
        end else begin
            h1 <= h0;
            h0 <= mkEntry(vcount_in, hcount_in, vsync_in, hsync_in, vblnk_in, hblnk_in, rgb_in, mActX, mActY);
            mPrevVb <= vblnk_in;
            if (mReady && pos_valid) begin
                mPendX <= pos_x; mPendY <= pos_y; mReady <= 1'b0;
            end else if (!mReady && vblnk_in && !mPrevVb) begin
                mActX <= mPendX; mActY <= mPendY; mReady <= 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            checkOutput("vcount_out", 12'(vcount_out), 12'(h1.vc));
            checkOutput("hcount_out", 12'(hcount_out), 12'(h1.hc));
            checkOutput("vsync_out", 12'(vsync_out), 12'(h1.vs));
            checkOutput("hsync_out", 12'(hsync_out), 12'(h1.hs));
            checkOutput("vblnk_out", 12'(vblnk_out), 12'(h1.vb));
            checkOutput("hblnk_out", 12'(hblnk_out), 12'(h1.hb));
            checkOutput("rgb_out", rgb_out, h1.rgb);
            checkOutput("pos_ready", 12'(pos_ready), 12'(mReady));
            if (hblnk_out || vblnk_out)
                checkOutput("blank_rgb", rgb_out, 12'h000);
            else if (!rst)
                seen[int'(vcount_out) * 2048 + int'(hcount_out)] = rgb_out;
        end
    end

    task automatic checkPixel(input int x, input int y, input logic [11:0] exp);
        int key;
        key = y * 2048 + x;
        if (seen.exists(key)) begin
            checkOutput($sformatf("pix_%0d_%0d", x, y), seen[key], exp);
        end else begin
            checks++;
            failures++;
            $display("[TB] FAIL pix_%0d_%0d actual=not_displayed required=%h", x, y, exp);
        end
    endtask

    task automatic applyStimulus(input int hc, input int vc, input logic [11:0] rgb,
                                 input logic valid, input logic rstVal);
        logic wasRst;
        @(posedge clk);
        #1;
        wasRst    = rst;
        hcount_in = 11'(hc);
        vcount_in = 11'(vc);
        hsync_in  = (hc >= 840 && hc < 968);
        vsync_in  = (vc >= 601 && vc < 605);
        hblnk_in  = (hc >= 800);
        vblnk_in  = (vc >= 600);
        rgb_in    = rgb;
        pos_valid = valid;
        rst       = rstVal;
        if (rstVal && !wasRst) begin
            #1;
            checkOutput("rst_rgb", rgb_out, 12'h000);
            checkOutput("rst_hcount", 12'(hcount_out), 12'h000);
            checkOutput("rst_vblnk", 12'(vblnk_out), 12'h000);
            checkOutput("rst_ready", 12'(pos_ready), 12'h001);
        end
        frameCycle++;
    endtask

    // pulseAt: cycle index of a one-cycle request, -1 none, -2 on the frame-start cycle.
    task automatic driveFrame(input int pulseAt, input logic rndMode, input int rstAt);
        int lines[$];
        int cols[$];
        int blankCols[$];
        int vbCols[$];
        logic valid, rstVal;
        logic [11:0] rgb;
        lines = '{0, 1, 63, 64, 199, 200, 263, 264, 300, 500, 589, 590, 598, 599};
        cols  = '{0, 1, 47, 48, 99, 100, 147, 148, 300, 500, 779, 780, 799};
        blankCols = '{800, 850, 900, 1000, 1055};
        vbCols = '{0, 500, 900};
        for (int i = 0; i < 3; i++) lines.push_back(int'($urandom_range(0, 599)));
        for (int i = 0; i < 6; i++) cols.push_back(int'($urandom_range(0, 799)));
        lines.sort();
        cols.sort();
        foreach (blankCols[i]) cols.push_back(blankCols[i]);
        seen.delete();
        frameCycle = 0;
        foreach (lines[l]) begin
            foreach (cols[c]) begin
                valid  = rndMode ? ($urandom_range(0, 39) == 0) : (frameCycle == pulseAt);
                rgb    = rndMode ? 12'($urandom) : BG;
                rstVal = (rstAt >= 0 && frameCycle >= rstAt && frameCycle < rstAt + 3);
                if (rndMode) begin
                    pos_x = 11'($urandom_range(0, 1100));
                    pos_y = 11'($urandom_range(0, 800));
                end
                applyStimulus(cols[c], lines[l], rgb, valid, rstVal);
                if (!rndMode && pulseAt >= 0 && frameCycle == pulseAt + 2 && rstAt < 0)
                    checkOutput("ready_after_req", 12'(pos_ready), 12'h000);
            end
        end
        for (int vc = 600; vc < 628; vc++) begin
            foreach (vbCols[c]) begin
                valid = rndMode ? ($urandom_range(0, 39) == 0) : (pulseAt == -2 && vc == 600 && c == 0);
                rgb   = rndMode ? 12'($urandom) : BG;
                applyStimulus(vbCols[c], vc, rgb, valid, 1'b0);
                if (!rndMode && vc == 600 && c == 0 && pulseAt >= 0 && rstAt < 0)
                    checkOutput("ready_at_fs", 12'(pos_ready), 12'h000);
                if (!rndMode && vc == 600 && c == 1 && pulseAt >= 0 && rstAt < 0)
                    checkOutput("ready_after_fs", 12'(pos_ready), 12'h001);
                if (!rndMode && vc == 600 && c == 1 && pulseAt == -2)
                    checkOutput("ready_fs_req", 12'(pos_ready), 12'h000);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        vcount_in = '0; hcount_in = '0;
        vsync_in = 1'b0; hsync_in = 1'b0; vblnk_in = 1'b0; hblnk_in = 1'b0;
        rgb_in = '0; pos_x = '0; pos_y = '0; pos_valid = 1'b0;
        #5;
        rst = 1'b1;
        started = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", 12'(pos_ready), 12'h001);
        checkOutput("reset_rgb", rgb_out, 12'h000);
        checkOutput("reset_vcount", 12'(vcount_out), 12'h000);
        rst = 1'b0;

        driveFrame(-1, 1'b0, -1);
        checkPixel(0, 0, RC);
        checkPixel(48, 0, BG);
        checkPixel(0, 64, BG);
        checkPixel(47, 63, RC);
        checkPixel(100, 200, BG);

        pos_x = 11'd100; pos_y = 11'd200;
        driveFrame(50, 1'b0, -1);
        checkPixel(0, 0, RC);
        checkPixel(100, 200, BG);

        driveFrame(-1, 1'b0, -1);
        checkPixel(100, 200, RC);
        checkPixel(147, 263, RC);
        checkPixel(148, 200, BG);
        checkPixel(100, 264, BG);
        checkPixel(99, 200, BG);
        checkPixel(100, 199, BG);
        checkPixel(0, 0, BG);

        pos_x = 11'd300; pos_y = 11'd300;
        driveFrame(-2, 1'b0, -1);
        checkPixel(100, 200, RC);
        driveFrame(-1, 1'b0, -1);
        checkPixel(100, 200, RC);
        checkPixel(300, 300, BG);

        pos_x = 11'd780; pos_y = 11'd590;
        driveFrame(50, 1'b0, -1);
        checkPixel(300, 300, RC);
        checkPixel(100, 200, BG);

        driveFrame(-1, 1'b0, -1);
        checkPixel(780, 590, RC);
        checkPixel(799, 599, RC);
        checkPixel(799, 590, RC);
        checkPixel(779, 590, BG);
        checkPixel(780, 589, BG);
        checkPixel(0, 0, BG);
        checkPixel(0, 590, BG);
        checkPixel(780, 0, BG);
        checkPixel(300, 300, BG);

        pos_x = 11'd500; pos_y = 11'd500;
        driveFrame(50, 1'b0, 100);
        driveFrame(-1, 1'b0, -1);
        checkPixel(0, 0, RC);
        checkPixel(47, 63, RC);
        checkPixel(500, 500, BG);
        checkPixel(780, 590, BG);

        for (int f = 0; f < 6; f++) begin
            driveFrame(-1, 1'b1, -1);
        end

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
